// File: rtl/sevenseg_scan_driver.sv
// sevenseg_scan_driver
// Time-multiplexed driver for a common-anode multi-digit seven-segment display.
// Digits are scanned one at a time at a programmable rate. Digit data is
// double-buffered: loads land in staging and move to the displayed (active)
// copy only at a frame boundary, so a frame never shows a mix of old and new
// values. Per-digit enable, decimal point and leading-zero suppression are
// supported. Segment, dp and anode outputs are registered and active-low.
module sevenseg_scan_driver #(
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic                    lz_en,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int IW = $clog2(NUM_DIGITS);
  localparam int TW = $clog2(REFRESH_DIV);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_DIGITS - 1);
  localparam logic [TW-1:0] LAST_TICK = TW'(REFRESH_DIV - 1);

  // Refresh timing
  logic [TW-1:0] r_tick;
  logic [IW-1:0] r_idx;
  logic          w_tick_wrap;
  logic          w_boundary;

  // Staging copy, written by load
  logic [4*NUM_DIGITS-1:0] r_stg_digits;
  logic [NUM_DIGITS-1:0]   r_stg_en;
  logic [NUM_DIGITS-1:0]   r_stg_dp;
  logic                    r_pending;

  // Active copy, the only one ever displayed
  logic [4*NUM_DIGITS-1:0] r_act_digits;
  logic [NUM_DIGITS-1:0]   r_act_en;
  logic [NUM_DIGITS-1:0]   r_act_dp;

  // Per-slot display decisions
  logic [NUM_DIGITS-1:0]   w_suppress;
  logic                    w_zero_run;
  logic [NUM_DIGITS-1:0]   w_sel;
  logic [3:0]              w_nib;
  logic                    w_lit;
  logic [6:0]              w_seg_dec;

  // Registered outputs
  logic [6:0]              r_seg;
  logic                    r_dp;
  logic [NUM_DIGITS-1:0]   r_an;

  // Hex to active-low {g,f,e,d,c,b,a}
  function automatic logic [6:0] f_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  assign w_tick_wrap = (r_tick == LAST_TICK);
  assign w_boundary  = w_tick_wrap && (r_idx == LAST_IDX);
  // Decoded from reset-cleared registers, so it is low while rst is high
  assign frame_done  = w_boundary;

  // Tick counter and scan index; idx steps once per tick wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tick <= '0;
      r_idx  <= '0;
    end else if (w_tick_wrap) begin
      r_tick <= '0;
      r_idx  <= w_boundary ? '0 : r_idx + IW'(1);
    end else begin
      r_tick <= r_tick + TW'(1);
    end
  end

  // Staging capture and frame-boundary transfer into the active copy.
  // A load on the boundary cycle goes straight to active and leaves
  // nothing pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stg_digits <= '0;
      r_stg_en     <= '0;
      r_stg_dp     <= '0;
      r_pending    <= 1'b0;
      r_act_digits <= '0;
      r_act_en     <= '0;
      r_act_dp     <= '0;
    end else begin
      if (load) begin
        r_stg_digits <= digits_in;
        r_stg_en     <= digit_en;
        r_stg_dp     <= dp_in;
      end
      if (load && w_boundary) begin
        r_act_digits <= digits_in;
        r_act_en     <= digit_en;
        r_act_dp     <= dp_in;
        r_pending    <= 1'b0;
      end else if (load) begin
        r_pending    <= 1'b1;
      end else if (w_boundary && r_pending) begin
        r_act_digits <= r_stg_digits;
        r_act_en     <= r_stg_en;
        r_act_dp     <= r_stg_dp;
        r_pending    <= 1'b0;
      end
    end
  end

  // Leading-zero mask: walk from the top digit down, suppressing while every
  // digit at or above the current one is zero; digit 0 is always kept
  always_comb begin
    w_suppress = '0;
    w_zero_run = 1'b1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      w_zero_run = w_zero_run & (r_act_digits[4*(NUM_DIGITS-1-i) +: 4] == 4'h0);
      if (i != NUM_DIGITS - 1) begin
        w_suppress[NUM_DIGITS-1-i] = w_zero_run & lz_en;
      end
    end
  end

  // One-hot anode selection for the current scan index
  always_comb begin
    w_sel = '0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      w_sel[k] = (r_idx == IW'(k));
    end
  end

  assign w_nib     = r_act_digits[4*r_idx +: 4];
  assign w_lit     = r_act_en[r_idx] & ~w_suppress[r_idx];
  assign w_seg_dec = f_decode(w_nib);

  // Output register: lit slot drives one anode low, blank slot drives none
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_an  <= '1;
      r_seg <= '1;
      r_dp  <= 1'b1;
    end else if (w_lit) begin
      r_an  <= ~w_sel;
      r_seg <= w_seg_dec;
      r_dp  <= ~r_act_dp[r_idx];
    end else begin
      r_an  <= '1;
      r_seg <= '1;
      r_dp  <= 1'b1;
    end
  end

  assign an  = r_an;
  assign seg = r_seg;
  assign dp  = r_dp;

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Bench for sevenseg_scan_driver (NUM_DIGITS=4, REFRESH_DIV=4).
// A frame-position model (edges since reset, mod 16) predicts every output
// cycle; table vectors and hand sequences check specific slots.
module tb_sevenseg_scan_driver;

  localparam int N   = 4;
  localparam int DIV = 4;
  localparam int FRAME = N * DIV;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] digits_in;
  logic [3:0]  digit_en;
  logic [3:0]  dp_in;
  logic        load;
  logic        lz_en;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;

  int total = 0;
  int bad   = 0;

  // Model state
  int          m_cyc;
  logic [15:0] m_act_d, m_stg_d;
  logic [3:0]  m_act_en, m_stg_en, m_act_dp, m_stg_dp;
  logic        m_pend;

  logic [6:0] seg_lut [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  typedef struct packed {
    logic [15:0] d;
    logic [3:0]  en;
    logic [3:0]  dpi;
    logic        lz;
    logic [15:0] an4;   // slot k expected anodes at [4k+:4]
    logic [27:0] sg4;   // slot k expected segments at [7k+:7]
    logic [3:0]  dpo;   // slot k expected dp at [k]
  } vec_t;

  vec_t tbl [6];

  sevenseg_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .digits_in(digits_in), .digit_en(digit_en),
    .dp_in(dp_in), .load(load), .lz_en(lz_en), .seg(seg), .dp(dp),
    .an(an), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Expected {an, seg, dp} for a slot showing digit idx
  function automatic logic [11:0] model_out(input int idx, input logic [15:0] d,
                                            input logic [3:0] en, input logic [3:0] dpm,
                                            input logic lz);
    logic lit;
    logic [15:0] upper;
    logic [3:0] one;
    upper = d >> (4 * idx);
    lit = en[idx] && !(lz && idx != 0 && upper == 16'h0);
    one = 4'b0001 << idx;
    if (!lit) return 12'hFFF;
    return {~one, seg_lut[d[4*idx +: 4]], ~dpm[idx]};
  endfunction

  task automatic model_reset();
    m_cyc = 0; m_pend = 1'b0;
    m_act_d = '0; m_act_en = '0; m_act_dp = '0;
    m_stg_d = '0; m_stg_en = '0; m_stg_dp = '0;
  endtask

  // One clock: predict, advance model at the edge, compare 1 time unit later
  task automatic step();
    logic [11:0] e;
    logic fd;
    logic boundary;
    if (rst) e = 12'hFFF;
    else e = model_out((m_cyc / DIV) % N, m_act_d, m_act_en, m_act_dp, lz_en);
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      boundary = (m_cyc % FRAME) == FRAME - 1;
      if (load && boundary) begin
        m_act_d = digits_in; m_act_en = digit_en; m_act_dp = dp_in;
        m_stg_d = digits_in; m_stg_en = digit_en; m_stg_dp = dp_in;
        m_pend = 1'b0;
      end else if (load) begin
        m_stg_d = digits_in; m_stg_en = digit_en; m_stg_dp = dp_in;
        m_pend = 1'b1;
      end else if (boundary && m_pend) begin
        m_act_d = m_stg_d; m_act_en = m_stg_en; m_act_dp = m_stg_dp;
        m_pend = 1'b0;
      end
      m_cyc++;
    end
    #1;
    fd = !rst && ((m_cyc % FRAME) == FRAME - 1);
    chk("scan", {19'h0, an, seg, dp, frame_done}, {19'h0, e, fd});
  endtask

  task automatic wait_frame();
    int n = 0;
    while (frame_done !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk("frame_wait", {31'h0, frame_done}, 32'h1);
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] en, input logic [3:0] dpi);
    digits_in = d; digit_en = en; dp_in = dpi; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic chk_slot(input string name, input logic [3:0] ea, input logic [6:0] es,
                          input logic ed);
    chk(name, {20'h0, an, seg, dp}, {20'h0, ea, es, ed});
  endtask

  initial begin
    tbl[0] = '{16'h3210, 4'hF, 4'h0, 1'b0, {4'b0111, 4'b1011, 4'b1101, 4'b1110},
               {7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000}, 4'b1111};
    tbl[1] = '{16'h0050, 4'hF, 4'h0, 1'b1, {4'b1111, 4'b1111, 4'b1101, 4'b1110},
               {7'b1111111, 7'b1111111, 7'b0010010, 7'b1000000}, 4'b1111};
    tbl[2] = '{16'h0000, 4'hF, 4'h0, 1'b1, {4'b1111, 4'b1111, 4'b1111, 4'b1110},
               {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000}, 4'b1111};
    tbl[3] = '{16'h8888, 4'b0101, 4'b0001, 1'b0, {4'b1111, 4'b1011, 4'b1111, 4'b1110},
               {7'b1111111, 7'b0000000, 7'b1111111, 7'b0000000}, 4'b1110};
    tbl[4] = '{16'hABCD, 4'hF, 4'b1010, 1'b0, {4'b0111, 4'b1011, 4'b1101, 4'b1110},
               {7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001}, 4'b0101};
    tbl[5] = '{16'h0E0F, 4'hF, 4'h0, 1'b1, {4'b1111, 4'b1011, 4'b1101, 4'b1110},
               {7'b1111111, 7'b0000110, 7'b1000000, 7'b0001110}, 4'b1111};

    rst = 1'b1; digits_in = '0; digit_en = '0; dp_in = '0; load = 1'b0; lz_en = 1'b0;
    model_reset();
    repeat (3) step();
    @(negedge clk) rst = 1'b0;

    // Table vectors: load mid-frame, then check every slot of the next frame
    for (int v = 0; v < 6; v++) begin
      lz_en = tbl[v].lz;
      repeat (5) step();
      do_load(tbl[v].d, tbl[v].en, tbl[v].dpi);
      wait_frame();
      step();
      for (int k = 0; k < N; k++) begin
        step();
        chk_slot($sformatf("vec%0d_slot%0d", v, k), tbl[v].an4[4*k +: 4],
                 tbl[v].sg4[7*k +: 7], tbl[v].dpo[k]);
        repeat (DIV - 1) step();
      end
    end

    // No tearing: load mid-frame while digit 1 is being shown
    lz_en = 1'b0;
    do_load(16'h3210, 4'hF, 4'h0);
    wait_frame(); step();
    wait_frame(); step();
    repeat (4) step();
    do_load(16'hABCD, 4'hF, 4'h0);
    repeat (4) step();
    chk_slot("tear_slot2", 4'b1011, 7'b0100100, 1'b1);
    repeat (4) step();
    chk_slot("tear_slot3", 4'b0111, 7'b0110000, 1'b1);
    repeat (4) step();
    chk_slot("tear_new_slot0", 4'b1110, 7'b0100001, 1'b1);

    // Boundary collision: load on the frame_done cycle bypasses staging
    repeat (3) step();
    do_load(16'h1111, 4'hF, 4'h0);
    wait_frame();
    do_load(16'h7777, 4'hF, 4'h0);
    step();
    chk_slot("collide_slot0", 4'b1110, 7'b1111000, 1'b1);
    wait_frame(); step(); step();
    chk_slot("collide_next_slot0", 4'b1110, 7'b1111000, 1'b1);

    // Asynchronous reset between edges, then first lit slot is digit 0
    repeat (6) step();
    #2 rst = 1'b1;
    #1 chk("async_rst", {19'h0, an, seg, dp, frame_done}, {19'h0, 4'hF, 7'h7F, 1'b1, 1'b0});
    model_reset();
    repeat (2) step();
    @(negedge clk) rst = 1'b0;
    do_load(16'h3210, 4'hF, 4'h0);
    begin
      int n = 0;
      while (an === 4'hF && n < 60) begin
        step();
        n++;
      end
    end
    chk("first_lit_after_rst", {28'h0, an}, {28'h0, 4'b1110});

    // Randomized traffic against the model
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 19) == 0) lz_en = ~lz_en;
      if ($urandom_range(0, 7) == 0) begin
        logic [15:0] d;
        d = 16'($urandom);
        for (int k = 0; k < N; k++)
          if ($urandom_range(0, 1) == 1) d[4*k +: 4] = 4'h0;
        do_load(d, 4'($urandom), 4'($urandom));
      end else begin
        step();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
